arith_right_shifter_seq: RTL and testbench



---
 rtl/arith_right_shifter_seq_pkg.sv | 18 +
 rtl/arith_right_shifter_seq_if.sv | 43 ++++
 rtl/arith_shift_right_1.sv | 16 +
 rtl/arith_right_shifter_seq.sv | 96 +++++++++
 tb/tb_arith_right_shifter_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_right_shifter_seq_pkg.sv
// Package shifter_pkg: constants shared by the shifter family.
//   - FSM state encoding for the sequential shifters (IDLE/SHIFT/DONE).
//   - Default WIDTH/SHW, shared with the combinational left shifter.
//   - count_width(): width of a down-counter that must hold 0..w.
package shifter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SHW   = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/arith_right_shifter_seq_if.sv
// arith_right_shifter_seq_if: request/result bundle of the sequential
// arithmetic right shifter.
//   start/a/shamt : request, driven by the master. start is only looked at
//                   while the shifter is idle; a and shamt are captured
//                   together with an accepted start.
//   busy/done     : status. busy is high in SHIFT and DONE; done is a
//                   one-cycle pulse during which x/cout (and sticky) are valid.
//   x/cout        : result register and last bit shifted out of the LSB.
//   sticky        : OR of all bits shifted out (only with STICKY_EN defined).
//   state         : debug view of the FSM state register.
// Optional feature macro: STICKY_EN.
interface arith_right_shifter_seq_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] x;
  logic             cout;
`ifdef STICKY_EN
  logic             sticky;
`endif
  logic [1:0]       state;

`ifdef STICKY_EN
  modport master (output start, a, shamt,
                  input  busy, done, x, cout, sticky, state);
  modport slave  (input  start, a, shamt,
                  output busy, done, x, cout, sticky, state);
`else
  modport master (output start, a, shamt,
                  input  busy, done, x, cout, state);
  modport slave  (input  start, a, shamt,
                  output busy, done, x, cout, state);
`endif

endinterface

// File: rtl/arith_shift_right_1.sv
// arith_shift_right_1: combinational single-step arithmetic right shift.
//   d           : operand
//   q           : d shifted right by one, sign bit replicated
//   shifted_out : the LSB of d that falls off the end
module arith_shift_right_1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             shifted_out
);

  assign q           = {d[WIDTH-1], d[WIDTH-1:1]};
  assign shifted_out = d[0];

endmodule

// File: rtl/arith_right_shifter_seq.sv
// arith_right_shifter_seq: multi-cycle arithmetic right shifter
// (signed divide-by-2^n path). One bit position per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, priority over start
//   bus : arith_right_shifter_seq_if.slave (start/a/shamt in,
//         busy/done/x/cout[/sticky]/state out)
// Optional feature macro: STICKY_EN adds the sticky output and register.
// Handshake: a request is accepted on a rising edge where state is IDLE and
// start is high; requests arriving while busy are dropped, never queued.
// done pulses exactly once per accepted request, k+1 cycles after acceptance
// where k = min(shamt, WIDTH).
module arith_right_shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic                     clk,
  input  logic                     rst,
  arith_right_shifter_seq_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] x_step;
  logic             cout_q;
  logic             step_out;
`ifdef STICKY_EN
  logic             sticky_q;
`endif

  // Shift amounts at or beyond WIDTH all behave like WIDTH: the result is
  // pure sign fill.
  always_comb begin
    k = CW'(WIDTH);
    if (int'(bus.shamt) < WIDTH) k = CW'(bus.shamt);
  end

  arith_shift_right_1 #(.WIDTH(WIDTH)) u_step (
    .d           (x_q),
    .q           (x_step),
    .shifted_out (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_q      <= '0;
      cout_q   <= 1'b0;
      count    <= '0;
`ifdef STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q      <= bus.a;
            cout_q   <= 1'b0;
            count    <= k;
`ifdef STICKY_EN
            sticky_q <= 1'b0;
`endif
            state    <= (k == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          x_q      <= x_step;
          cout_q   <= step_out;
          count    <= count - CW'(1);
`ifdef STICKY_EN
          sticky_q <= sticky_q | step_out;
`endif
          if (count == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status is decoded from the state flops only.
  assign bus.busy   = (state == SHIFT) || (state == DONE);
  assign bus.done   = (state == DONE);
  assign bus.x      = x_q;
  assign bus.cout   = cout_q;
  assign bus.state  = state;
`ifdef STICKY_EN
  assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_arith_right_shifter_seq.sv
// tb_arith_right_shifter_seq: self-checking bench for arith_right_shifter_seq
// at WIDTH=4, SHW=3. Directed table, random operations against a signed
// arithmetic model, reset and mid-operation abort sequences.
module tb_arith_right_shifter_seq;
  import shifter_pkg::*;

  localparam int W   = 4;
  localparam int S   = 3;
  localparam int WIN = 12;

  logic clk;
  logic rst;

  arith_right_shifter_seq_if #(.WIDTH(W), .SHW(S)) bus ();

  arith_right_shifter_seq #(.WIDTH(W), .SHW(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_fail;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed divide by 2^k with floor, from plain arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [S-1:0] shamt,
                       output logic [W-1:0] x, output logic cout,
                       output logic sticky, output int lat);
    int k;
    int v;
    int p;
    v = (a >= 8) ? int'(a) - 16 : int'(a);
    k = (int'(shamt) > W) ? W : int'(shamt);
    p = 1 << k;
    // floor division for negatives
    x = W'((v >= 0) ? (v / p) : -((-v + p - 1) / p));
    cout   = (k == 0) ? 1'b0 : a[k-1];
    sticky = ((int'(a) % p) != 0);
    lat    = k + 1;
  endtask

  // ---------------- driver ----------------
  // Issues one request, optionally re-pulses start while busy, and watches
  // a fixed window of cycles.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [S-1:0] shamt,
                        input logic poke, input logic [W-1:0] ex, input logic ec,
                        input logic es, input int lat);
    int done_cnt;
    int done_at;
    int busy_cnt;
    logic [W-1:0] x_at;
    logic c_at;
    logic s_at;
    done_cnt = 0; done_at = -1; busy_cnt = 0;
    x_at = '0; c_at = 1'b0; s_at = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.shamt = shamt;
    @(posedge clk);
    for (int n = 1; n <= WIN; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          x_at = bus.x;
          c_at = bus.cout;
`ifdef STICKY_EN
          s_at = bus.sticky;
`endif
        end
      end
      if (n == 1) begin
        bus.start = poke;
        bus.a     = ~a;
        bus.shamt = 3'd2;
      end else if (n == 2) begin
        bus.start = 1'b0;
      end
    end
    exp_q.push_back(ex);
    check({name, ".done_at"},  32'(done_at),  32'(lat));
    check({name, ".done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, ".busy_cnt"}, 32'(busy_cnt), 32'(lat));
    check({name, ".x"},        32'(x_at),     32'(exp_q.pop_front()));
    check({name, ".cout"},     32'(c_at),     32'(ec));
`ifdef STICKY_EN
    check({name, ".sticky"},   32'(s_at),     32'(es));
`else
    if (s_at !== 1'b0) check({name, ".sticky_absent"}, 32'(s_at), 32'd0);
    if (es === 1'bx) check({name, ".es"}, 32'(es), 32'd0);
`endif
    check({name, ".x_hold"},   32'(bus.x),    32'(ex));
    check({name, ".idle"},     32'(bus.state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [S-1:0] shamt;
    logic [W-1:0] x;
    logic         cout;
    logic         sticky;
    int           lat;
    logic         poke;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [W-1:0] ra;
    logic [S-1:0] rs;
    logic [W-1:0] mx;
    logic mc;
    logic ms;
    int ml;
    int done_seen;

    n_vec = 0; n_fail = 0;
    tbl[0] = '{4'b1000, 3'd1, 4'b1100, 1'b0, 1'b0, 2, 1'b0};
    tbl[1] = '{4'b0111, 3'd2, 4'b0001, 1'b1, 1'b1, 3, 1'b0};
    tbl[2] = '{4'b0100, 3'd2, 4'b0001, 1'b0, 1'b0, 3, 1'b1};
    tbl[3] = '{4'b1011, 3'd5, 4'b1111, 1'b1, 1'b1, 5, 1'b0};
    tbl[4] = '{4'b0101, 3'd0, 4'b0101, 1'b0, 1'b0, 1, 1'b1};
    tbl[5] = '{4'b0110, 3'd7, 4'b0000, 1'b0, 1'b1, 5, 1'b1};
    tbl[6] = '{4'b1111, 3'd3, 4'b1111, 1'b1, 1'b1, 4, 1'b0};

    // Reset with start held high: no operation may begin, no done pulse.
    rst = 1'b1; bus.start = 1'b1; bus.a = 4'b1111; bus.shamt = 3'd1;
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("reset.x",    32'(bus.x),    32'd0);
    check("reset.cout", 32'(bus.cout), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
`ifdef STICKY_EN
    check("reset.sticky", 32'(bus.sticky), 32'd0);
`endif
    bus.start = 1'b0; rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("reset.no_done", 32'(done_seen), 32'd0);
    check("reset.hold_x",  32'(bus.x),     32'd0);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].shamt, tbl[i].poke,
             tbl[i].x, tbl[i].cout, tbl[i].sticky, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 15));
      rs = S'($urandom_range(0, 7));
      model(ra, rs, mx, mc, ms, ml);
      run_op($sformatf("rnd%0d", i), ra, rs, 1'($urandom_range(0, 1)), mx, mc, ms, ml);
    end

    // Abort: reset lands while shifting; no done, registers cleared.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b1010; bus.shamt = 3'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.state", 32'(bus.state), 32'(IDLE));
    check("abort.x",     32'(bus.x),     32'd0);
    check("abort.busy",  32'(bus.busy),  32'd0);
    check("abort.cout",  32'(bus.cout),  32'd0);
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);

    // Operation after abort still works.
    run_op("post_abort", 4'b1010, 3'd3, 1'b0, 4'b1111, 1'b0, 1'b1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
